// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// divider sizing and small operand helpers.
package hilo_mdu_pkg;

  localparam logic [2:0] MDU_OP_NONE  = 3'd0;
  localparam logic [2:0] MDU_OP_MULT  = 3'd1;
  localparam logic [2:0] MDU_OP_MULTU = 3'd2;
  localparam logic [2:0] MDU_OP_DIV   = 3'd3;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  // Operations that occupy the unit for more than the issue cycle.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/hilo_mdu_div_radix2.sv
// Radix-2 restoring divider: 32 shift/subtract iterations on operand magnitudes,
// then one fix-up cycle in which signed quotient/remainder are presented.
module hilo_mdu_div_radix2
  import hilo_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        abort_i,
  input  logic        sgn_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        last_o,
  output logic        valid_o,
  output logic [31:0] q_o,
  output logic [31:0] r_o
);

  logic [63:0]          rq_q;
  logic [31:0]          dvs_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 run_q;
  logic                 fix_q;
  logic                 neg_q_q;
  logic                 neg_r_q;

  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic [63:0] rq_next;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract when the 33-bit partial remainder covers the divisor.
  always_comb begin
    rem_sh  = {rq_q[63:32], rq_q[31]};
    rem_sub = rem_sh[31:0] - dvs_q;
    if (rem_sh >= {1'b0, dvs_q}) begin
      rq_next = {rem_sub, rq_q[30:0], 1'b1};
    end else begin
      rq_next = {rem_sh[31:0], rq_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || abort_i) begin
      rq_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      fix_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (load_i) begin
      rq_q    <= {32'd0, mag32(a_i, sgn_i)};
      dvs_q   <= mag32(b_i, sgn_i);
      cnt_q   <= '0;
      run_q   <= 1'b1;
      fix_q   <= 1'b0;
      neg_q_q <= sgn_i & (a_i[31] ^ b_i[31]);
      neg_r_q <= sgn_i & a_i[31];
    end else if (run_q) begin
      rq_q  <= rq_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_o) begin
        run_q <= 1'b0;
        fix_q <= 1'b1;
      end
    end else if (fix_q) begin
      fix_q <= 1'b0;
    end
  end

  assign last_o  = run_q && (cnt_q == DIV_CNT_W'(DIV_ITERS - 1));
  assign valid_o = fix_q;
  assign q_o     = neg_q_q ? (~rq_q[31:0] + 32'd1)  : rq_q[31:0];
  assign r_o     = neg_r_q ? (~rq_q[63:32] + 32'd1) : rq_q[63:32];

endmodule

// File: rtl/hilo_mdu.sv
// Multiply/divide unit with architectural HI/LO registers for the EX stage.
// busy stalls the pipeline while a multiply or divide is in flight.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        rhl_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] RHLOut,
  output logic [1:0]  dbg_state
);

  localparam int MUL_CNT_W = $clog2(MUL_CYCLES) + 1;

  mdu_state_e           state_q;
  logic [31:0]          hi_q;
  logic [31:0]          lo_q;
  logic [31:0]          op_a_q;
  logic [31:0]          op_b_q;
  logic                 mul_sgn_q;
  logic [MUL_CNT_W-1:0] mul_cnt_q;
  logic [63:0]          product_q;
  logic                 done_q;

  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] prod_c;
  logic [63:0] mul_res;
  logic        mul_last;
  logic        accept;
  logic        div_load;
  logic        div_last;
  logic        div_valid;
  logic [31:0] div_q;
  logic [31:0] div_r;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign mul_a_ext = mul_sgn_q ? {{32{op_a_q[31]}}, op_a_q} : {32'd0, op_a_q};
  assign mul_b_ext = mul_sgn_q ? {{32{op_b_q[31]}}, op_b_q} : {32'd0, op_b_q};
  assign prod_c    = mul_a_ext * mul_b_ext;
  assign mul_res   = (MUL_CYCLES == 1) ? prod_c : product_q;
  assign mul_last  = (mul_cnt_q == MUL_CNT_W'(MUL_CYCLES - 1));

  assign accept   = (state_q == ST_IDLE) && start && !flush;
  assign div_load = accept && is_div_op(op);

  hilo_mdu_div_radix2 u_div (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (div_load),
    .abort_i (flush),
    .sgn_i   (op == MDU_OP_DIV),
    .a_i     (a),
    .b_i     (b),
    .last_o  (div_last),
    .valid_o (div_valid),
    .q_o     (div_q),
    .r_o     (div_r)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      mul_sgn_q <= 1'b0;
      mul_cnt_q <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q   <= ST_IDLE;
        mul_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              case (op)
                MDU_OP_MULT, MDU_OP_MULTU: begin
                  op_a_q    <= a;
                  op_b_q    <= b;
                  mul_sgn_q <= (op == MDU_OP_MULT);
                  mul_cnt_q <= '0;
                  state_q   <= ST_MUL;
                end
                MDU_OP_DIV, MDU_OP_DIVU: state_q <= ST_DIV;
                MDU_OP_MTHI:             hi_q    <= a;
                MDU_OP_MTLO:             lo_q    <= a;
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            product_q <= prod_c;
            if (mul_last) begin
              hi_q      <= mul_res[63:32];
              lo_q      <= mul_res[31:0];
              done_q    <= 1'b1;
              mul_cnt_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              mul_cnt_q <= mul_cnt_q + 1'b1;
            end
          end
          ST_DIV: begin
            if (div_last) state_q <= ST_FIX;
          end
          ST_FIX: begin
            // The divider presents fixed-up results for exactly this cycle.
            if (div_valid) begin
              hi_q   <= div_r;
              lo_q   <= div_q;
              done_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Combinational so the issuing instruction stalls in EX in its own cycle.
  assign busy      = (state_q != ST_IDLE) || (start && is_iter_op(op) && !flush);
  assign done      = done_q;
  assign RHLOut    = rhl_sel ? hi_q : lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed spec vectors, flush/reset aborts,
// ignored issues while busy, and randomized ops against an arithmetic model.
module tb_hilo_mdu;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = OP_NONE;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        rhl_sel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] RHLOut;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_fail = 0;

  hilo_mdu #(.MUL_CYCLES(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .rhl_sel   (rhl_sel),
    .busy      (busy),
    .done      (done),
    .RHLOut    (RHLOut),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: returns {HI, LO} ----------------
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp, sq, sr;
    logic [63:0] ux, uy;
    logic [31:0] q;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      OP_MULT:  begin sp = sx * sy; return sp; end
      OP_MULTU: return ux * uy;
      OP_DIVU:  if (y == 0) return {x, 32'hFFFF_FFFF}; else return {x % y, x / y};
      OP_DIV: begin
        if (y == 0) begin
          q = x[31] ? 32'd1 : 32'hFFFF_FFFF;
          return {x, q};
        end
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt, output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE; a = $urandom; b = $urandom;
    lat = 0;
    bcnt = 0;
    while (lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
    rhl_sel = 1'b1; #1 hi = RHLOut;
    rhl_sel = 1'b0; #1 lo = RHLOut;
  endtask

  task automatic write_hl(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    rhl_sel = 1'b1; #1 hi = RHLOut;
    rhl_sel = 1'b0; #1 lo = RHLOut;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] hi, lo;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_hl(hi, lo);
    n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_chk++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mult();
    int lat, bc;
    logic [31:0] hi, lo;
    do_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, lat, bc, hi, lo);
    n_chk++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mult_latency: got %0d expected %0d", lat, MUL_LAT); end
    n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_chk++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffe", lo); end
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, lat, bc, hi, lo);
    n_chk++; if (bc !== MUL_LAT) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected %0d", bc, MUL_LAT); end
    n_chk++; if (hi !== 32'd1) begin n_fail++; $display("FAIL multu_hi: got %h expected 1", hi); end
    n_chk++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
  endtask

  task automatic test_div();
    int lat, bc;
    logic [31:0] hi, lo;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, hi, lo);
    n_chk++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", lat, DIV_LAT); end
    n_chk++; if (bc !== DIV_LAT) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected %0d", bc, DIV_LAT); end
    n_chk++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
    n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
    do_op(OP_DIVU, 32'd100, 32'd7, lat, bc, hi, lo);
    n_chk++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    n_chk++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    do_op(OP_DIVU, 32'h1234, 32'd0, lat, bc, hi, lo);
    n_chk++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h expected ffffffff", lo); end
    n_chk++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL divu_zero_hi: got %h expected 00001234", hi); end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, hi, lo);
    n_chk++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 0", hi); end
  endtask

  task automatic test_flush();
    int lat, bc, dcnt;
    logic [31:0] hi, lo;
    write_hl(OP_MTHI, 32'd5);
    write_hl(OP_MTLO, 32'd6);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    dcnt = 0;
    repeat (9) begin @(posedge clk); #1; if (done) dcnt++; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
    repeat (40) begin @(posedge clk); #1; if (done) dcnt++; end
    n_chk++; if (dcnt !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", dcnt); end
    read_hl(hi, lo);
    n_chk++; if (hi !== 32'd5) begin n_fail++; $display("FAIL flush_hi: got %h expected 5", hi); end
    n_chk++; if (lo !== 32'd6) begin n_fail++; $display("FAIL flush_lo: got %h expected 6", lo); end
    // issue together with flush is dropped, including MTHI
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9; flush = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
    op = OP_MTHI; a = 32'd99;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE; flush = 1'b0;
    read_hl(hi, lo);
    n_chk++; if (hi !== 32'd5) begin n_fail++; $display("FAIL flush_mthi_hi: got %h expected 5", hi); end
    // flush on the completion edge of a multiply
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd8;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    dcnt = 0;
    repeat (MUL_LAT - 1) begin @(posedge clk); #1; if (done) dcnt++; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; if (done) dcnt++;
    repeat (3) begin @(posedge clk); #1; if (done) dcnt++; end
    n_chk++; if (dcnt !== 0) begin n_fail++; $display("FAIL flush_complete_done: got %0d pulses expected 0", dcnt); end
    read_hl(hi, lo);
    n_chk++; if (lo !== 32'd6) begin n_fail++; $display("FAIL flush_complete_lo: got %h expected 6", lo); end
    do_op(OP_MULTU, 32'd7, 32'd8, lat, bc, hi, lo);
    n_chk++; if (lo !== 32'd56) begin n_fail++; $display("FAIL post_flush_mult_lo: got %h expected 38", lo); end
  endtask

  task automatic test_reset_mid_op();
    int dcnt;
    logic [31:0] hi, lo;
    write_hl(OP_MTHI, 32'h77);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    repeat (5) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); resetn = 1'b1;
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dcnt++; end
    read_hl(hi, lo);
    n_chk++; if (dcnt !== 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d pulses expected 0", dcnt); end
    n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi: got %h expected 0", hi); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mt_and_ignore();
    int lat;
    logic [31:0] hi, lo;
    @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'hA5A5_A5A5; rhl_sel = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    n_chk++; if (RHLOut !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mtlo_rhlout: got %h expected a5a5a5a5", RHLOut); end
    write_hl(OP_MTHI, 32'h1111_1111);
    // MULTU 3*5, then try MTLO and DIVU while busy
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MTLO; a = 32'hDEAD;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during_mul: got %b expected 1", busy); end
    @(posedge clk); #1;
    rhl_sel = 1'b0; #1;
    n_chk++; if (RHLOut !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ignored_mtlo: got %h expected a5a5a5a5", RHLOut); end
    op = OP_DIVU; a = 32'd1; b = 32'd1;
    lat = 1;
    while (lat < 100) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    start = 1'b0; op = OP_NONE;
    if (!done) lat = -1;
    n_chk++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL ignore_mul_latency: got %0d expected %0d", lat, MUL_LAT); end
    read_hl(hi, lo);
    n_chk++; if (lo !== 32'd15) begin n_fail++; $display("FAIL ignore_mul_lo: got %h expected f", lo); end
    n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_mul_hi: got %h expected 0", hi); end
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_divu_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [31:0] hi, lo;
    logic [63:0] exp;
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bc, hi, lo);
    n_chk++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL b2b_mult: got %h%h expected 4000000000000000", hi, lo); end
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bc, hi, lo);
    exp = model(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    n_chk++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL b2b_div: got %h%h expected %h", hi, lo, exp); end
    do_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, lat, bc, hi, lo);
    n_chk++; if ({hi, lo} !== 64'hFFFF_FFF0_0000_0001) begin n_fail++; $display("FAIL div_neg_by_zero: got %h%h expected fffffff000000001", hi, lo); end
  endtask

  task automatic test_random();
    int lat, bc, exp_lat;
    logic [2:0] o;
    logic [31:0] x, y, hi, lo;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(1, 4));
      case ($urandom_range(0, 7))
        0: x = 32'd0;
        1: x = 32'h8000_0000;
        2: x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      exp = model(o, x, y);
      exp_lat = (o == OP_MULT || o == OP_MULTU) ? MUL_LAT : DIV_LAT;
      do_op(o, x, y, lat, bc, hi, lo);
      n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency op=%0d: got %0d expected %0d", o, lat, exp_lat); end
      n_chk++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h%h expected %h", o, x, y, hi, lo, exp); end
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom;
        write_hl(($urandom_range(0, 1) == 1) ? OP_MTHI : OP_MTLO, x);
        write_hl(OP_MTHI, x ^ 32'h0F0F_0F0F);
        read_hl(hi, lo);
        n_chk++; if (hi !== (x ^ 32'h0F0F_0F0F)) begin n_fail++; $display("FAIL rand_mthi: got %h expected %h", hi, x ^ 32'h0F0F_0F0F); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid_op();
    test_mt_and_ignore();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
